// File: rtl/cmsdk_apb_simple_master.sv
// cmsdk_apb_simple_master
// APB3 initiator: takes one request at a time from a valid/ready channel, runs
// a single SETUP/ACCESS transfer on the shared APB bus, and returns read data
// and error status on a valid/ready response channel.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   When defined, an ACCESS phase that waits TIMEOUT_CYCLES cycles without
//   PREADY is abandoned and answered with RSP_ERR=1, RSP_RDATA=0.
//
// Ports
//   PCLK, PRESET           clock, synchronous active-high reset
//   REQ_VALID/READY        request handshake (READY high only while idle)
//   REQ_WRITE/ADDR/WDATA   request payload
//   RSP_VALID/READY        response handshake
//   RSP_RDATA/RSP_ERR      response payload (RDATA is 0 for writes)
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB initiator outputs
//   PREADY/PRDATA/PSLVERR  APB slave returns
module cmsdk_apb_simple_master #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  REQ_VALID,
    output logic                  REQ_READY,
    input  logic                  REQ_WRITE,
    input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [31:0]           REQ_WDATA,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic [31:0]           RSP_RDATA,
    output logic                  RSP_ERR,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]           PWDATA,
    input  logic                  PREADY,
    input  logic [31:0]           PRDATA,
    input  logic                  PSLVERR
);

    // Elaboration-time parameter sanity check.
    if (ADDR_WIDTH < 16 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("cmsdk_apb_simple_master: illegal ADDR_WIDTH or TIMEOUT_CYCLES");
    end

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                state_q,     state_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic                  pwrite_q,    pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic [31:0]           pwdata_q,    pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
    logic [15:0]           wait_cnt_q,  wait_cnt_d;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    state_d   = ST_SETUP;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    pwrite_d  = REQ_WRITE;
                    // Word-aligned address; byte lanes are not used on this bus.
                    paddr_d   = REQ_ADDR & ~ADDR_WIDTH'(3);
                    pwdata_d  = REQ_WDATA;
                end
            end
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_d = 16'd0;
`endif
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? 32'd0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = ST_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
`endif
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    assign REQ_READY = (state_q == ST_IDLE);
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign RSP_VALID = rsp_valid_q;
    assign RSP_RDATA = rsp_rdata_q;
    assign RSP_ERR   = rsp_err_q;

endmodule

// File: tb/tb_cmsdk_apb_simple_master.sv
// Directed bench for cmsdk_apb_simple_master: cycle-exact checks of the APB
// phases, response channel, backpressure, mid-transfer reset and (when the
// timeout feature is built in) the ACCESS timeout.
module tb_cmsdk_apb_simple_master;

    localparam int unsigned AW = 16;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 256;
`endif

    logic          PCLK;
    logic          PRESET;
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          REQ_WRITE;
    logic [AW-1:0] REQ_ADDR;
    logic [31:0]   REQ_WDATA;
    logic          RSP_VALID;
    logic          RSP_READY;
    logic [31:0]   RSP_RDATA;
    logic          RSP_ERR;
    logic          PSEL;
    logic          PENABLE;
    logic          PWRITE;
    logic [AW-1:0] PADDR;
    logic [31:0]   PWDATA;
    logic          PREADY;
    logic [31:0]   PRDATA;
    logic          PSLVERR;

    int n_checks = 0;
    int n_errors = 0;

    cmsdk_apb_simple_master #(
        .ADDR_WIDTH     (AW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_WRITE (REQ_WRITE),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WDATA (REQ_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_RDATA (RSP_RDATA),
        .RSP_ERR   (RSP_ERR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PREADY    (PREADY),
        .PRDATA    (PRDATA),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic req(input logic wr, input logic [AW-1:0] addr, input logic [31:0] wd);
        REQ_VALID = 1'b1;
        REQ_WRITE = wr;
        REQ_ADDR  = addr;
        REQ_WDATA = wd;
    endtask

    initial begin
        PRESET = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_ADDR = '0;
        REQ_WDATA = 32'd0; RSP_READY = 1'b0; PREADY = 1'b0; PRDATA = 32'd0;
        PSLVERR = 1'b0;
        tick(); tick();
        chk("rst_psel",      32'(PSEL),      32'd0);
        chk("rst_penable",   32'(PENABLE),   32'd0);
        chk("rst_pwrite",    32'(PWRITE),    32'd0);
        chk("rst_paddr",     32'(PADDR),     32'd0);
        chk("rst_pwdata",    PWDATA,         32'd0);
        chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("rst_rsp_rdata", RSP_RDATA,      32'd0);
        chk("rst_rsp_err",   32'(RSP_ERR),   32'd0);
        chk("rst_req_ready", 32'(REQ_READY), 32'd1);
        PRESET = 1'b0;

        // Zero-wait write.
        PREADY = 1'b1; RSP_READY = 1'b1;
        req(1'b1, 16'h3004, 32'hA5A5_0001);
        chk("t1_req_ready", 32'(REQ_READY), 32'd1);
        tick(); REQ_VALID = 1'b0;                        // T+1 SETUP
        chk("t1_setup_psel",    32'(PSEL),    32'd1);
        chk("t1_setup_penable", 32'(PENABLE), 32'd0);
        chk("t1_paddr",         32'(PADDR),   32'h3004);
        chk("t1_pwrite",        32'(PWRITE),  32'd1);
        chk("t1_pwdata",        PWDATA,       32'hA5A5_0001);
        chk("t1_setup_rdy",     32'(REQ_READY), 32'd0);
        tick();                                          // T+2 ACCESS
        chk("t1_acc_psel",    32'(PSEL),      32'd1);
        chk("t1_acc_penable", 32'(PENABLE),   32'd1);
        chk("t1_acc_rsp",     32'(RSP_VALID), 32'd0);
        tick();                                          // T+3 RESP
        chk("t1_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("t1_rsp_err",   32'(RSP_ERR),   32'd0);
        chk("t1_rsp_rdata", RSP_RDATA,      32'd0);
        chk("t1_rsp_psel",  32'(PSEL),      32'd0);
        chk("t1_rsp_pen",   32'(PENABLE),   32'd0);
        tick();                                          // IDLE
        chk("t1_idle_rsp",   32'(RSP_VALID), 32'd0);
        chk("t1_idle_rdy",   32'(REQ_READY), 32'd1);
        chk("t1_idle_paddr", 32'(PADDR),     32'h3004);

        // Read with three wait states.
        PREADY = 1'b0;
        req(1'b0, 16'h5008, 32'h0);
        tick(); REQ_VALID = 1'b0;                        // T+1
        tick();                                          // T+2
        for (int i = 0; i < 3; i++) begin
            chk("t2_wait_penable", 32'(PENABLE),   32'd1);
            chk("t2_wait_paddr",   32'(PADDR),     32'h5008);
            chk("t2_wait_pwrite",  32'(PWRITE),    32'd0);
            chk("t2_wait_rsp",     32'(RSP_VALID), 32'd0);
            tick();
        end
        PREADY = 1'b1; PRDATA = 32'hDEAD_BEEF;           // T+5
        chk("t2_last_penable", 32'(PENABLE), 32'd1);
        chk("t2_last_paddr",   32'(PADDR),   32'h5008);
        tick();                                          // T+6
        PREADY = 1'b0; PRDATA = 32'h1234_5678;
        chk("t2_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("t2_rsp_rdata", RSP_RDATA,      32'hDEAD_BEEF);
        tick();
        chk("t2_idle_rsp",   32'(RSP_VALID), 32'd0);
        chk("t2_idle_rdata", RSP_RDATA,      32'hDEAD_BEEF);

        // Slave error, unaligned address.
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h0BAD_F00D;
        req(1'b0, 16'h1003, 32'h0);
        tick(); REQ_VALID = 1'b0;
        chk("t3_paddr_align", 32'(PADDR), 32'h1000);
        tick(); tick();
        chk("t3_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("t3_rsp_err",   32'(RSP_ERR),   32'd1);
        chk("t3_rsp_rdata", RSP_RDATA,      32'h0BAD_F00D);
        PSLVERR = 1'b0;
        tick();

        // Response backpressure with a new request held pending.
        RSP_READY = 1'b0; PRDATA = 32'h1122_3344;
        req(1'b0, 16'h4000, 32'h0);
        tick();                                          // SETUP
        req(1'b1, 16'h2010, 32'h55AA_55AA);
        tick();                                          // ACCESS
        tick();                                          // RESP
        PRDATA = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_bp_valid", 32'(RSP_VALID), 32'd1);
            chk("t4_bp_ready", 32'(REQ_READY), 32'd0);
            chk("t4_bp_rdata", RSP_RDATA,      32'h1122_3344);
            chk("t4_bp_paddr", 32'(PADDR),     32'h4000);
            tick();
        end
        RSP_READY = 1'b1;
        chk("t4_hs_valid", 32'(RSP_VALID), 32'd1);
        tick();                                          // IDLE
        chk("t4_idle_ready", 32'(REQ_READY), 32'd1);
        chk("t4_idle_valid", 32'(RSP_VALID), 32'd0);
        chk("t4_idle_psel",  32'(PSEL),      32'd0);
        tick(); REQ_VALID = 1'b0;                        // SETUP of second
        chk("t4_next_psel",   32'(PSEL),   32'd1);
        chk("t4_next_paddr",  32'(PADDR),  32'h2010);
        chk("t4_next_pwrite", 32'(PWRITE), 32'd1);
        chk("t4_next_pwdata", PWDATA,      32'h55AA_55AA);
        tick(); tick();
        chk("t4_next_rsp",   32'(RSP_VALID), 32'd1);
        chk("t4_next_rdata", RSP_RDATA,      32'd0);
        tick();

        // Reset during ACCESS.
        PREADY = 1'b0;
        req(1'b1, 16'h7FFC, 32'hCAFE_0001);
        tick(); REQ_VALID = 1'b0;
        tick();
        chk("t5_in_access", 32'(PENABLE), 32'd1);
        PRESET = 1'b1;
        tick();
        chk("t5_psel",      32'(PSEL),      32'd0);
        chk("t5_penable",   32'(PENABLE),   32'd0);
        chk("t5_rsp_valid", 32'(RSP_VALID), 32'd0);
        chk("t5_req_ready", 32'(REQ_READY), 32'd1);
        chk("t5_paddr",     32'(PADDR),     32'd0);
        chk("t5_pwdata",    PWDATA,         32'd0);
        PRESET = 1'b0; PREADY = 1'b1;
        req(1'b1, 16'h6000, 32'h0000_0006);
        tick(); REQ_VALID = 1'b0;
        chk("t5_after_psel",  32'(PSEL),  32'd1);
        chk("t5_after_paddr", 32'(PADDR), 32'h6000);
        tick(); tick();
        chk("t5_after_rsp", 32'(RSP_VALID), 32'd1);
        chk("t5_after_err", 32'(RSP_ERR),   32'd0);
        tick();
        chk("t5_after_idle", 32'(REQ_READY), 32'd1);

`ifdef APB_MASTER_TIMEOUT_EN
        // ACCESS timeout after four wait cycles.
        PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
        req(1'b0, 16'h8000, 32'h0);
        tick(); REQ_VALID = 1'b0;                        // T+1
        tick();                                          // T+2
        for (int i = 0; i < 4; i++) begin
            chk("t6_wait_penable", 32'(PENABLE),   32'd1);
            chk("t6_wait_rsp",     32'(RSP_VALID), 32'd0);
            tick();
        end
        chk("t6_rsp_valid", 32'(RSP_VALID), 32'd1);
        chk("t6_rsp_err",   32'(RSP_ERR),   32'd1);
        chk("t6_rsp_rdata", RSP_RDATA,      32'd0);
        chk("t6_psel",      32'(PSEL),      32'd0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
